reg_dump_unit: RTL
==================

# reg_dump_unit

Debug readout engine for the single-cycle CPU. It walks the register file through a dedicated read port and streams each `(index, value)` pair out over a valid/ready handshake. This gives benches and on-chip debug logic an ordered register snapshot without reaching into CPU hierarchy. It sits beside the CPU's register file and is triggered either by a start pulse or by a programmable cycle count.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register-file address width
- `DUMP_COUNT`, 13, number of registers dumped, from r0 to r(DUMP_COUNT-1); legal range 1 to 2^ADDR_W
- `TRIG_CYCLE`, 25, cycle count for the auto-trigger (used only with the macro defined)

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: dump request, sampled in IDLE only.
- `rf_addr_o` out ADDR_W: register-file read address.
- `rf_data_i` in DATA_W: combinational read data for `rf_addr_o`.
- `dump_valid_o` out 1: output word valid.
- `dump_ready_i` in 1: consumer accepts.
- `dump_idx_o` out ADDR_W: register index of the current word.
- `dump_data_o` out DATA_W: register value.
- `busy_o` out 1: dump in progress.
- `done_o` out 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states are IDLE, READ, SEND and DONE.
- IDLE → READ on trigger: `start_i`=1, or the auto-trigger fires. The index counter `idx` is cleared to 0.
- READ drives `rf_addr_o`=`idx` and registers `rf_data_i` into the data holding register on the clock edge. The FSM always moves to SEND.
- SEND holds `dump_valid_o`=1, `dump_idx_o`=`idx` and `dump_data_o` equal to the captured value.
  - On `dump_valid_o & dump_ready_i`: if `idx`==`DUMP_COUNT`-1, go to DONE; otherwise increment `idx` and go to READ.
  - With `dump_ready_i`=0, SEND persists and all outputs stay stable.
- DONE asserts `done_o` for exactly one cycle, then returns to IDLE.
- `busy_o`=1 in READ, SEND and DONE.
- `start_i` is ignored while busy. There is no queuing.
- Consistency: each register is sampled in its own READ cycle. The snapshot is not atomic across registers; this is intended.
- `rf_addr_o` holds `idx` in every state and holds 0 in IDLE.
- Index arithmetic is unsigned ADDR_W. `idx` never exceeds `DUMP_COUNT`-1, so there is no wrap.

## Timing
- Reset values: every output is 0, the state is IDLE, `idx`=0 and the data register is 0.
- Reset asserted mid-dump aborts the dump immediately. After release the block is in IDLE and there is no resume.
- Trigger latency:
  - `start_i` is high at edge N, so READ runs in cycle N+1.
  - `dump_valid_o` rises after edge N+1, with r0 data.
- Per-register cost is 2 cycles (READ then SEND) when `dump_ready_i` is held high.
- A full dump with ready held high takes 2·`DUMP_COUNT` cycles, then 1 DONE cycle.
- `dump_valid_o` never drops without a handshake.

## Configuration
- `REG_DUMP_AUTO_TRIG_EN` defined: a free-running cycle counter starts at 0 after reset and increments every clock.
  - When the counter equals `TRIG_CYCLE`-1, the block triggers exactly once, as if `start_i` were pulsed.
  - If the block is already busy at that point, the auto-trigger is lost.
  - The counter saturates; it never re-triggers.
- Not defined: the counter logic is absent and only `start_i` triggers a dump. `TRIG_CYCLE` is unused.

## Structure
- Shared package `reg_dump_pkg` holds:
  - the state enum (IDLE/READ/SEND/DONE);
  - default `DATA_W`/`ADDR_W` constants;
  - the `DUMP_COUNT` default of 13.
- One sub-module, `reg_dump_trig`: the saturating cycle counter and one-shot trigger, instantiated only under `REG_DUMP_AUTO_TRIG_EN`.

## Test plan
- **Basic dump:** reg file preloaded with r_k = k·3, `start_i` pulsed, ready held high. Required: 13 words (idx 0..12, data 0,3,…,36) on alternating cycles, and `done_o` one cycle after idx 12 is accepted.
- **Backpressure:** ready low for 5 cycles while idx 4 is valid. Required: `dump_idx_o`=4 and data stay stable, with no skipped or duplicated index.
- **Busy start:** `start_i` pulsed while idx 7 is pending. Required: the dump continues unchanged, and there is no second dump after `done_o`.
- **Reset mid-dump:** `rst_i` driven low during SEND of idx 5. Required: all outputs are 0 immediately; after release, `busy_o`=0 and a new start dumps from idx 0.
- **Auto-trigger (macro on):** no `start_i`. Required: READ in the cycle after the counter reaches 24; exactly one dump; no trigger at cycle 50.
- **DUMP_COUNT=1:** start pulsed. Required: a single word (idx 0), then `done_o`, then IDLE.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and default sizes for the register dump unit.
//   state_t        - dump FSM states (IDLE/READ/SEND/DONE)
//   DEF_DATA_W     - default register width
//   DEF_ADDR_W     - default register-file address width
//   DEF_DUMP_COUNT - default number of registers dumped (r0 upward)
//   DEF_TRIG_CYCLE - default auto-trigger cycle (REG_DUMP_AUTO_TRIG_EN builds)
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_DUMP_COUNT = 13;
  localparam int unsigned DEF_TRIG_CYCLE = 25;

endpackage

// File: rtl/reg_dump_if.sv
// reg_dump_if: register-file read port, dump stream and status of the
// register dump unit.
//   start_i      - dump request
//   rf_addr_o    - register-file read address
//   rf_data_i    - combinational read data for rf_addr_o
//   dump_valid_o - output word valid
//   dump_ready_i - consumer accepts
//   dump_idx_o   - register index of the current word
//   dump_data_o  - register value
//   busy_o       - dump in progress
//   done_o       - one-cycle pulse after the last word is accepted
// master: the dump unit; slave: CPU register file plus consumer.
interface reg_dump_if
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              start_i;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_i;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [ADDR_W-1:0] dump_idx_o;
  logic [DATA_W-1:0] dump_data_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, rf_data_i, dump_ready_i,
    output rf_addr_o, dump_valid_o, dump_idx_o, dump_data_o, busy_o, done_o
  );

  modport slave (
    output start_i, rf_data_i, dump_ready_i,
    input  rf_addr_o, dump_valid_o, dump_idx_o, dump_data_o, busy_o, done_o
  );

endinterface

// File: rtl/reg_dump_trig.sv
// reg_dump_trig: saturating cycle counter with a one-shot trigger.
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   trig_o - high during the single cycle the counter equals TRIG_CYCLE-1
// Used by reg_dump_unit only when REG_DUMP_AUTO_TRIG_EN is defined.
module reg_dump_trig
  import reg_dump_pkg::*;
#(
  parameter int unsigned TRIG_CYCLE = DEF_TRIG_CYCLE
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic trig_o
);

  localparam int unsigned CW = $clog2(TRIG_CYCLE + 1);
  localparam logic [CW-1:0] SAT_VAL  = CW'(TRIG_CYCLE);
  localparam logic [CW-1:0] FIRE_VAL = CW'(TRIG_CYCLE - 1);

  logic [CW-1:0] cnt;

  // Counter parks one past the fire value, so the compare matches only once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (cnt != SAT_VAL) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign trig_o = (cnt == FIRE_VAL);

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the register file r0..r(DUMP_COUNT-1) through a read
// port and streams (index, value) pairs over a valid/ready handshake.
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-low reset
//   bus   - reg_dump_if.master: start, register-file read port, dump stream,
//           busy/done status
// Build option: REG_DUMP_AUTO_TRIG_EN adds a one-shot trigger TRIG_CYCLE
// cycles after reset; without it only start_i launches a dump.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DUMP_COUNT = DEF_DUMP_COUNT,
  parameter int unsigned TRIG_CYCLE = DEF_TRIG_CYCLE
) (
  input logic        clk_i,
  input logic        rst_i,
  reg_dump_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_COUNT - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              trig;

`ifdef REG_DUMP_AUTO_TRIG_EN
  logic auto_trig;

  reg_dump_trig #(
    .TRIG_CYCLE(TRIG_CYCLE)
  ) u_trig (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .trig_o(auto_trig)
  );

  assign trig = bus.start_i | auto_trig;
`else
  logic unused_trig_cycle;
  assign unused_trig_cycle = ^TRIG_CYCLE;
  assign trig = bus.start_i;
`endif

  // Status outputs are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state  <= READ;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        READ: begin
          data_q  <= bus.rf_data_i;
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (bus.dump_ready_i) begin
            valid_q <= 1'b0;
            if (idx == LAST_IDX) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          // Clearing idx here keeps rf_addr_o at 0 throughout IDLE.
          done_q <= 1'b0;
          busy_q <= 1'b0;
          idx    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_addr_o    = idx;
  assign bus.dump_idx_o   = idx;
  assign bus.dump_data_o  = data_q;
  assign bus.dump_valid_o = valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule
